// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-to-1 arbitrated output mux.
package mux_pkg;

    localparam int ARB_MODE_FIXED = 0;
    localparam int ARB_MODE_RR    = 1;

    // Select-index width, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_arb_nto1_rr_arbiter.sv
// One-hot arbiter: fixed priority (lowest index) or round-robin from a start pointer.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N    = 3,
    parameter int MODE = ARB_MODE_RR,
    localparam int SELW = sel_width(N)
) (
    input  logic [N-1:0]    eligible,
    input  logic [SELW-1:0] ptr,
    input  logic            advance,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx,
    output logic            any_grant,
    output logic [SELW-1:0] next_ptr
);

    int unsigned start;
    int unsigned idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        next_ptr  = ptr;
        idx       = 0;
        start     = (MODE == ARB_MODE_RR) ? 32'(ptr) : 32'd0;
        // Scan upward from the start index, wrapping; first eligible hit wins.
        for (int unsigned k = 0; k < N; k++) begin
            idx = (start + k) % N;
            if (!any_grant && eligible[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SELW'(idx);
            end
        end
        if (advance && any_grant && (MODE == ARB_MODE_RR)) begin
            next_ptr = (32'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mux_arb_nto1.sv
// N-to-1 registered mux with valid/ready on every port, built-in arbitration
// and an optional forced-select path.
module mux_arb_nto1
    import mux_pkg::*;
#(
    parameter int DATAWIDTH  = 32,
    parameter int NUM_INPUTS = 3,
    parameter int ARB_MODE   = ARB_MODE_RR,
    localparam int SELW = sel_width(NUM_INPUTS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_INPUTS-1:0]           in_valid,
    input  logic [NUM_INPUTS*DATAWIDTH-1:0] in_data,
    output logic [NUM_INPUTS-1:0]           in_ready,
    input  logic                            force_sel_en,
    input  logic [SELW-1:0]                 force_sel,
    output logic                            out_valid,
    output logic [DATAWIDTH-1:0]            out_data,
    output logic [SELW-1:0]                 out_sel,
    input  logic                            out_ready,
    output logic                            sel_err
);

    logic                  out_valid_q, out_valid_d;
    logic [DATAWIDTH-1:0]  out_data_q,  out_data_d;
    logic [SELW-1:0]       out_sel_q,   out_sel_d;
    logic                  sel_err_q,   sel_err_d;
    logic [SELW-1:0]       rr_ptr_q,    rr_ptr_d;

    logic                  accept;
    logic                  force_ok;
    logic                  xfer;
    logic [NUM_INPUTS-1:0] eligible;
    logic [NUM_INPUTS-1:0] grant;
    logic [SELW-1:0]       grant_idx;
    logic                  any_grant;
    logic [SELW-1:0]       next_ptr;

    always_comb begin
        accept   = !out_valid_q || out_ready;
        force_ok = 32'(force_sel) < 32'(NUM_INPUTS);
        if (!force_sel_en) begin
            eligible = in_valid;
        end else if (force_ok) begin
            eligible = in_valid & (NUM_INPUTS'(1) << force_sel);
        end else begin
            eligible = '0;
        end
    end

    rr_arbiter #(
        .N    (NUM_INPUTS),
        .MODE (ARB_MODE)
    ) u_arb (
        .eligible  (eligible),
        .ptr       (rr_ptr_q),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant),
        .next_ptr  (next_ptr)
    );

    always_comb begin
        xfer        = any_grant && accept;
        // Gated by reset so no producer sees a ready while state is being cleared.
        in_ready    = (accept && !reset) ? grant : '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        rr_ptr_d    = rr_ptr_q;
        sel_err_d   = force_sel_en && !force_ok && accept;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[32'(grant_idx)*DATAWIDTH +: DATAWIDTH];
            out_sel_d   = grant_idx;
            rr_ptr_d    = next_ptr;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            sel_err_q   <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            sel_err_q   <= sel_err_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Directed bench: fixed-priority N=3, round-robin N=3 and round-robin N=4 instances.
module tb_mux_arb_nto1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // fixed-priority, N=3
    logic [2:0]  fx_in_valid, fx_in_ready;
    logic [23:0] fx_in_data;
    logic        fx_force_en, fx_out_valid, fx_out_ready, fx_sel_err;
    logic [1:0]  fx_force_sel, fx_out_sel;
    logic [7:0]  fx_out_data;

    // round-robin, N=3
    logic [2:0]  rr_in_valid, rr_in_ready;
    logic [23:0] rr_in_data;
    logic        rr_force_en, rr_out_valid, rr_out_ready, rr_sel_err;
    logic [1:0]  rr_force_sel, rr_out_sel;
    logic [7:0]  rr_out_data;

    // round-robin, N=4
    logic [3:0]  r4_in_valid, r4_in_ready;
    logic [31:0] r4_in_data;
    logic        r4_force_en, r4_out_valid, r4_out_ready, r4_sel_err;
    logic [1:0]  r4_force_sel, r4_out_sel;
    logic [7:0]  r4_out_data;

    mux_arb_nto1 #(.DATAWIDTH(8), .NUM_INPUTS(3), .ARB_MODE(0)) dut_fx (
        .clk(clk), .reset(reset), .in_valid(fx_in_valid), .in_data(fx_in_data),
        .in_ready(fx_in_ready), .force_sel_en(fx_force_en), .force_sel(fx_force_sel),
        .out_valid(fx_out_valid), .out_data(fx_out_data), .out_sel(fx_out_sel),
        .out_ready(fx_out_ready), .sel_err(fx_sel_err));

    mux_arb_nto1 #(.DATAWIDTH(8), .NUM_INPUTS(3), .ARB_MODE(1)) dut_rr (
        .clk(clk), .reset(reset), .in_valid(rr_in_valid), .in_data(rr_in_data),
        .in_ready(rr_in_ready), .force_sel_en(rr_force_en), .force_sel(rr_force_sel),
        .out_valid(rr_out_valid), .out_data(rr_out_data), .out_sel(rr_out_sel),
        .out_ready(rr_out_ready), .sel_err(rr_sel_err));

    mux_arb_nto1 #(.DATAWIDTH(8), .NUM_INPUTS(4), .ARB_MODE(1)) dut_r4 (
        .clk(clk), .reset(reset), .in_valid(r4_in_valid), .in_data(r4_in_data),
        .in_ready(r4_in_ready), .force_sel_en(r4_force_en), .force_sel(r4_force_sel),
        .out_valid(r4_out_valid), .out_data(r4_out_data), .out_sel(r4_out_sel),
        .out_ready(r4_out_ready), .sel_err(r4_sel_err));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        fx_in_valid = 3'b111; rr_in_valid = 3'b111; r4_in_valid = 4'b1111;
        fx_in_data = 24'h0C0B0A; rr_in_data = 24'h0C0B0A; r4_in_data = 32'h0D0C0B0A;
        fx_force_en = 0; rr_force_en = 0; r4_force_en = 0;
        fx_force_sel = 0; rr_force_sel = 0; r4_force_sel = 0;
        fx_out_ready = 1; rr_out_ready = 1; r4_out_ready = 1;
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({fx_out_valid, fx_out_data, fx_out_sel, fx_sel_err, fx_in_ready} !== 15'd0) begin
            errors++;
            $display("FAIL reset_fx: got v=%b d=%h s=%0d e=%b rdy=%b required all zero",
                     fx_out_valid, fx_out_data, fx_out_sel, fx_sel_err, fx_in_ready);
        end
        checks++;
        if ({rr_out_valid, rr_out_data, rr_out_sel, rr_sel_err, rr_in_ready} !== 15'd0) begin
            errors++;
            $display("FAIL reset_rr: got v=%b d=%h s=%0d e=%b rdy=%b required all zero",
                     rr_out_valid, rr_out_data, rr_out_sel, rr_sel_err, rr_in_ready);
        end
        checks++;
        if ({r4_out_valid, r4_out_data, r4_out_sel, r4_sel_err, r4_in_ready} !== 16'd0) begin
            errors++;
            $display("FAIL reset_r4: got v=%b d=%h s=%0d e=%b rdy=%b required all zero",
                     r4_out_valid, r4_out_data, r4_out_sel, r4_sel_err, r4_in_ready);
        end
        fx_in_valid = 0; rr_in_valid = 0; r4_in_valid = 0;
        #3 reset = 1'b0;
        step();
    endtask

    task automatic test_fixed();
        fx_in_valid = 3'b111;
        #1;
        checks++;
        if (fx_in_ready !== 3'b001) begin
            errors++;
            $display("FAIL fixed_ready0: got %b required 001", fx_in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (fx_out_valid !== 1'b1 || fx_out_sel !== 2'd0 || fx_out_data !== 8'h0A ||
                fx_in_ready !== 3'b001) begin
                errors++;
                $display("FAIL fixed_cycle%0d: got v=%b s=%0d d=%h rdy=%b required 1 0 0a 001",
                         i, fx_out_valid, fx_out_sel, fx_out_data, fx_in_ready);
            end
        end
        fx_in_valid = 0;
        step();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_sel [5];
        logic [7:0] exp_dat [5];
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        exp_dat = '{8'h0A, 8'h0B, 8'h0C, 8'h0A, 8'h0B};
        rr_in_valid = 3'b111;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (rr_out_valid !== 1'b1 || rr_out_sel !== exp_sel[i] || rr_out_data !== exp_dat[i]) begin
                errors++;
                $display("FAIL rr_seq%0d: got v=%b s=%0d d=%h required 1 %0d %h",
                         i, rr_out_valid, rr_out_sel, rr_out_data, exp_sel[i], exp_dat[i]);
            end
        end
        rr_in_valid = 0;
        step();
        checks++;
        if (rr_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain: got out_valid=%b required 0", rr_out_valid);
        end
    endtask

    task automatic test_backpressure();
        // rr_ptr is 2 here, so channel 2 (0x11) is captured first.
        rr_in_data   = 24'h110B0A;
        rr_in_valid  = 3'b111;
        rr_out_ready = 0;
        step();
        checks++;
        if (rr_out_valid !== 1'b1 || rr_out_data !== 8'h11 || rr_out_sel !== 2'd2) begin
            errors++;
            $display("FAIL bp_capture: got v=%b d=%h s=%0d required 1 11 2",
                     rr_out_valid, rr_out_data, rr_out_sel);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rr_out_data !== 8'h11 || rr_out_valid !== 1'b1 || rr_in_ready !== 3'b000) begin
                errors++;
                $display("FAIL bp_stall%0d: got d=%h v=%b rdy=%b required 11 1 000",
                         i, rr_out_data, rr_out_valid, rr_in_ready);
            end
            step();
        end
        rr_out_ready = 1;
        #1;
        checks++;
        if (rr_in_ready !== 3'b001) begin
            errors++;
            $display("FAIL bp_release_ready: got %b required 001", rr_in_ready);
        end
        step();
        checks++;
        if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'd0 || rr_out_data !== 8'h0A) begin
            errors++;
            $display("FAIL bp_next: got v=%b s=%0d d=%h required 1 0 0a",
                     rr_out_valid, rr_out_sel, rr_out_data);
        end
        rr_in_valid = 0;
        step();
    endtask

    task automatic test_forced();
        fx_force_en = 1; fx_force_sel = 2'd2; fx_in_valid = 3'b111; fx_out_ready = 1;
        #1;
        checks++;
        if (fx_in_ready !== 3'b100) begin
            errors++;
            $display("FAIL force_ready: got %b required 100", fx_in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (fx_out_sel !== 2'd2 || fx_out_data !== 8'h0C || fx_in_ready !== 3'b100 ||
                fx_sel_err !== 1'b0) begin
                errors++;
                $display("FAIL force_cycle%0d: got s=%0d d=%h rdy=%b e=%b required 2 0c 100 0",
                         i, fx_out_sel, fx_out_data, fx_in_ready, fx_sel_err);
            end
        end
        fx_force_sel = 2'd3;
        #1;
        checks++;
        if (fx_in_ready !== 3'b000) begin
            errors++;
            $display("FAIL force_bad_ready: got %b required 000", fx_in_ready);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (fx_sel_err !== 1'b1 || fx_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL force_bad%0d: got e=%b v=%b required 1 0", i, fx_sel_err, fx_out_valid);
            end
        end
        // Illegal index while stalled: no accept, so no error pulse.
        fx_force_en = 0; fx_out_ready = 0;
        step();
        fx_force_en = 1;
        step();
        checks++;
        if (fx_sel_err !== 1'b0 || fx_out_valid !== 1'b1 || fx_out_sel !== 2'd0) begin
            errors++;
            $display("FAIL force_bad_stalled: got e=%b v=%b s=%0d required 0 1 0",
                     fx_sel_err, fx_out_valid, fx_out_sel);
        end
        fx_force_en = 0; fx_in_valid = 0; fx_out_ready = 1;
        step();
        checks++;
        if (fx_sel_err !== 1'b0 || fx_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL force_clear: got e=%b v=%b required 0 0", fx_sel_err, fx_out_valid);
        end
    endtask

    task automatic test_reset_mid();
        // rr_ptr is 1; load 0x5A from channel 1 and stall it.
        rr_in_data   = 24'h115A0A;
        rr_in_valid  = 3'b010;
        rr_out_ready = 0;
        step();
        checks++;
        if (rr_out_valid !== 1'b1 || rr_out_data !== 8'h5A) begin
            errors++;
            $display("FAIL rst_mid_load: got v=%b d=%h required 1 5a", rr_out_valid, rr_out_data);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({rr_out_valid, rr_out_data, rr_out_sel, rr_sel_err, rr_in_ready} !== 15'd0) begin
            errors++;
            $display("FAIL rst_mid_async: got v=%b d=%h s=%0d e=%b rdy=%b required all zero",
                     rr_out_valid, rr_out_data, rr_out_sel, rr_sel_err, rr_in_ready);
        end
        rr_in_valid = 3'b110;
        #1 reset = 1'b0;
        #1;
        checks++;
        if (rr_in_ready !== 3'b010) begin
            errors++;
            $display("FAIL rst_mid_first_grant: got %b required 010", rr_in_ready);
        end
        step();
        checks++;
        if (rr_out_sel !== 2'd1 || rr_out_data !== 8'h5A || rr_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_out: got s=%0d d=%h v=%b required 1 5a 1",
                     rr_out_sel, rr_out_data, rr_out_valid);
        end
        rr_in_valid = 0; rr_out_ready = 1;
        step();
    endtask

    task automatic test_sparse();
        logic [3:0] vld [6];
        logic [3:0] rdy [6];
        vld = '{4'b0100, 4'b0010, 4'b1111, 4'b1000, 4'b1111, 4'b0000};
        // ptr: 0 -> 3 (grant 2), 3 -> 2 (grant 1), 2 -> 3 (grant 2), 3 -> 0 (grant 3, wrap), then grant 0
        rdy = '{4'b0100, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
        r4_out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            r4_in_valid = vld[i];
            #1;
            checks++;
            if (r4_in_ready !== rdy[i]) begin
                errors++;
                $display("FAIL sparse%0d: got rdy=%b required %b", i, r4_in_ready, rdy[i]);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_backpressure();
        test_forced();
        test_reset_mid();
        test_sparse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_arb_nto1.md
# mux_arb_nto1

Parametrised N-to-1 registered multiplexer with valid/ready handshakes on every input and on the output. It is the successor to the three-input operand/result select mux, and it adds three things: an arbitrary input count, built-in arbitration (fixed-priority or round-robin), and a one-entry output register. It sits between several producers (ALU, LSU, CSR read-back, and similar) and a single consumer port, such as a writeback or forwarding bus. An optional forced-select path keeps the old explicit-select behaviour available.

## Interface
- DATAWIDTH, default 32: width of each data channel.
- NUM_INPUTS, default 3: number of input channels; legal range is 2 to 16.
- ARB_MODE, default 1: 0 selects fixed priority (lowest index wins); 1 selects round-robin.
- SELW is derived as $clog2(NUM_INPUTS) and is not user-settable.

Ports:
- clk, input, 1: the single clock; all state is updated on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, NUM_INPUTS: per-channel valid.
- in_data, input, NUM_INPUTS*DATAWIDTH: flattened input data; channel i occupies bits [i*DATAWIDTH +: DATAWIDTH].
- in_ready, output, NUM_INPUTS: per-channel ready; combinational.
- force_sel_en, input, 1: when high, arbitration is bypassed and only force_sel is eligible.
- force_sel, input, SELW: forced channel index.
- out_valid, output, 1: registered output valid.
- out_data, output, DATAWIDTH: registered output data.
- out_sel, output, SELW: registered index of the channel that produced out_data.
- out_ready, input, 1: consumer ready.
- sel_err, output, 1: registered one-cycle pulse indicating an illegal forced index.

## Operation
- accept = !out_valid || out_ready. The output register can take new data in any cycle where it is empty or is being drained.
- Eligible set:
  - force_sel_en=0: all channels with in_valid[i]=1.
  - force_sel_en=1 and force_sel < NUM_INPUTS: only channel force_sel, and only if its in_valid is high.
  - force_sel_en=1 and force_sel >= NUM_INPUTS: the set is empty and no grant is made.
- Grant (one-hot, combinational, at most one bit set):
  - ARB_MODE=0: lowest eligible index.
  - ARB_MODE=1: the first eligible index at or above rr_ptr, searching upward and wrapping from NUM_INPUTS-1 to 0.
- in_ready[i] = grant[i] && accept. A transfer on channel i occurs when in_valid[i] && in_ready[i].
- On an input transfer from channel g:
  - out_data <= channel g data; out_sel <= g; out_valid <= 1.
  - In round-robin mode, rr_ptr <= (g == NUM_INPUTS-1) ? 0 : g+1.
- If out_ready=1 and no input transfer occurs, out_valid <= 0. out_data and out_sel hold their values.
- If out_valid=1 and out_ready=0, out_data and out_sel hold, and all in_ready bits are 0. This stall causes no loss or duplication of data.
- rr_ptr changes only on an input transfer. It is unaffected by forced grants in fixed-priority mode, and it is updated normally by forced grants in round-robin mode.
- sel_err <= force_sel_en && (force_sel >= NUM_INPUTS) && accept. It is a one-cycle pulse per cycle in which that condition holds.

## Timing
- Latency from an input transfer to out_valid is 1 cycle. Sustained throughput is one transfer per cycle while out_ready=1.
- The combinational paths are out_ready -> in_ready and in_valid/force_sel -> in_ready. There is no combinational path from in_* to out_*.
- Reset values: out_valid=0, out_data=0, out_sel=0, sel_err=0, rr_ptr=0. in_ready is 0 during reset.
- Reset asserted mid-transfer discards the held output word. The first grant after reset follows rr_ptr=0.
- Simultaneous drain and fill in the same cycle: out_valid stays 1 and the new word replaces the old one on that edge.

## Structure
- Package mux_pkg holds the ARB_MODE_FIXED=0 and ARB_MODE_RR=1 constants, plus a function that computes SELW with a minimum of 1.
- Sub-module rr_arbiter (parameters N and MODE) is the natural split. It takes the eligible vector, rr_ptr and an advance strobe, and returns the one-hot grant, the encoded grant index and the next pointer. The top level owns the output register and the handshake logic.

## Test plan
- Fixed mode, N=3, all three in_valid held high, out_ready=1: grants go 0,0,0. in_ready=3'b001. out_sel=0 from cycle 1 onward.
- Round-robin mode, N=3, all three valid, out_ready=1: out_sel sequence is 0,1,2,0,1. out_data follows channel data 0xA,0xB,0xC,0xA,0xB.
- Backpressure: out_ready=0 for 4 cycles after the first word 0x11 is captured. out_data holds 0x11, in_ready=0, and no rr_ptr change. Releasing out_ready produces the next word on the following cycle.
- Forced select: force_sel_en=1, force_sel=2, all channels valid. Only in_ready[2] rises and out_sel=2 every cycle. With force_sel=3 and N=3, there is no grant, sel_err pulses, and out_valid falls after the drain.
- Reset while out_valid=1 with data 0x5A: all outputs are 0 immediately, asynchronously. After release in round-robin mode with channels 1 and 2 valid, the first grant is 1.
- Sparse valid, round-robin mode, N=4, rr_ptr=3, only channel 1 valid: grant 1 and rr_ptr becomes 2. Wrap check: with rr_ptr=3 and only channel 3 valid, grant 3 and rr_ptr becomes 0.
